// File: rtl/det_bcd_formatter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : det_bcd_formatter
// Brief  : Latches a signed determinant and converts |det| to packed BCD with a
//          sequential double-dabble engine; sign and overflow flags held apart.
//          Optional leading-zero blank mask enabled by macro DET_BCD_BLANK_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
module det_bcd_formatter #(
    parameter int WIDTH      = 32,
    parameter int DIGITS     = 8,
    parameter int INT_DIGITS = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Ack,
    input  logic [WIDTH-1:0]      det,
    output logic [4*DIGITS-1:0]   Bcd,
    output logic                  Neg,
    output logic                  Ovf,
    output logic [DIGITS-1:0]     Blank,
    output logic                  q_Idle,
    output logic                  q_Load,
    output logic                  q_Shift,
    output logic                  q_Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_LOAD  = 4'b0010,
        S_SHIFT = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t                  r_state;
    logic [WIDTH-1:0]        r_det;
    logic [WIDTH-1:0]        r_sr;
    logic [4*INT_DIGITS-1:0] r_acc;
    logic [CW-1:0]           r_cnt;
    logic                    r_neg;
    logic                    r_nz;
    logic [4*DIGITS-1:0]     r_bcd;
    logic                    r_neg_out;
    logic                    r_ovf;

    logic [4*INT_DIGITS-1:0] w_acc_adj;
    logic [4*INT_DIGITS-1:0] w_acc_next;
    logic                    w_ovf_next;
    logic                    w_last;

    // Add-3 correction happens before the shift so no digit can exceed 9 after doubling.
    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_acc_next = (w_acc_adj << 1) | {{(4*INT_DIGITS-1){1'b0}}, r_sr[WIDTH-1]};
    assign w_last     = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));

    generate
        if (INT_DIGITS > DIGITS) begin : g_ovf
            assign w_ovf_next = |w_acc_next[4*INT_DIGITS-1:4*DIGITS];
        end else begin : g_no_ovf
            assign w_ovf_next = 1'b0;
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_det     <= '0;
            r_sr      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_nz      <= 1'b0;
            r_bcd     <= '0;
            r_neg_out <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_det   <= det;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Two's-complement negate; the most negative value maps to 2^(WIDTH-1).
                    r_sr    <= r_det[WIDTH-1] ? (~r_det + 1'b1) : r_det;
                    r_neg   <= r_det[WIDTH-1];
                    r_nz    <= |r_det;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_sr  <= r_sr << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bcd     <= w_acc_next[4*DIGITS-1:0];
                        r_neg_out <= r_neg & r_nz;
                        r_ovf     <= w_ovf_next;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (Ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DET_BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;

    assign w_blank_next[0] = 1'b0;
    generate
        for (genvar i = 1; i < DIGITS; i++) begin : g_blank
            assign w_blank_next[i] = ~w_ovf_next &&
                                     (w_acc_next[4*DIGITS-1:4*i] == '0);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_blank <= '0;
        end else if (w_last) begin
            r_blank <= w_blank_next;
        end
    end

    assign Blank = r_blank;
`else
    assign Blank = '0;
`endif

    assign Bcd     = r_bcd;
    assign Neg     = r_neg_out;
    assign Ovf     = r_ovf;
    assign q_Idle  = (r_state == S_IDLE);
    assign q_Load  = (r_state == S_LOAD);
    assign q_Shift = (r_state == S_SHIFT);
    assign q_Done  = (r_state == S_DONE);

endmodule
`default_nettype wire
